uart_rx_fsm: RTL

Control FSM for the UART receiver. It consumes the edge and bit counts from the RX edge/bit counter and the voted bit from the data sampler. It gates the enables for both of those stages, deserialises the frame LSB-first, checks parity and the stop bit, and presents the received word with a one-cycle valid strobe. Frame format is 1 start bit, DATA_WIDTH data bits, an optional parity bit and 1 stop bit.

---
 rtl/uart_rx_fsm.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: gates the edge/bit counter and sampler, deserialises
// the frame LSB-first and reports the word or a parity/stop error at frame end.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [4:0]            prescale,
    input  logic [4:0]            edge_count,
    input  logic [3:0]            bit_count,
    input  logic                  sampled_bit,
    input  logic                  sample_valid,
    output logic                  cnt_en,
    output logic                  samp_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned IdxW        = $clog2(DATA_WIDTH);
    localparam logic [3:0]  LastDataBit = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [DATA_WIDTH-1:0]   r_p_data;
    logic                    r_perr;
    logic                    r_serr;
    logic                    r_data_valid;
    logic                    r_par_err;
    logic                    r_stp_err;
    logic                    w_busy;
    logic                    w_eob;
    logic                    w_serr_final;
    logic                    w_idx_ok;
    logic [IdxW-1:0]         w_idx;

    assign w_busy = (r_state != StIdle);
    assign w_eob  = w_busy && (edge_count == prescale);

    // A stop sample coinciding with eob must still count towards the frame result.
    assign w_serr_final = sample_valid ? ~sampled_bit : r_serr;

    assign w_idx_ok = (bit_count >= 4'd1) && (bit_count <= LastDataBit);
    assign w_idx    = IdxW'(bit_count - 4'd1);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (!rx_in) w_state_next = StStart;
            StStart: begin
                if (sample_valid && sampled_bit) begin
                    w_state_next = StIdle;
                end else if (w_eob && (bit_count == 4'd0)) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                if (w_eob && (bit_count == LastDataBit)) begin
                    w_state_next = par_en ? StParity : StStop;
                end
            end
            StParity: if (w_eob) w_state_next = StStop;
            StStop:   if (w_eob) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_shreg      <= '0;
            r_p_data     <= '0;
            r_perr       <= 1'b0;
            r_serr       <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!rx_in) begin
                        r_shreg <= '0;
                        r_perr  <= 1'b0;
                        r_serr  <= 1'b0;
                    end
                end
                StData: begin
                    if (sample_valid && w_idx_ok) r_shreg[w_idx] <= sampled_bit;
                end
                StParity: begin
                    if (sample_valid) r_perr <= (sampled_bit != (^r_shreg ^ par_typ));
                end
                StStop: begin
                    if (sample_valid) r_serr <= ~sampled_bit;
                    if (w_eob) begin
                        if (!r_perr && !w_serr_final) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shreg;
                        end else begin
                            r_par_err <= r_perr;
                            r_stp_err <= w_serr_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt_en     = w_busy;
    assign samp_en    = w_busy;
    assign busy       = w_busy;
    assign p_data     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
